// File: rtl/servo_pwm_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : servo_pwm_multi_if                                              |
// | Purpose  : Bus bundle for servo_pwm_multi: target write port, per-channel  |
// |            enables, active-width readback and the PWM/frame outputs.       |
// | Ports    : wr_en / wr_ch / wr_pulse_us  - one-cycle target write           |
// |            ch_enable                    - per-channel enable               |
// |            rd_ch / rd_active_us         - readback select / result         |
// |            frame_start / pwm_out        - frame marker and servo outputs   |
// | Modports : master (controller side), slave (PWM block side)                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface servo_pwm_multi_if #(
   parameter int NUM_CH = 4
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                 wr_en;
   logic [CHW-1:0]       wr_ch;
   logic [15:0]          wr_pulse_us;
   logic [NUM_CH-1:0]    ch_enable;
   logic [CHW-1:0]       rd_ch;
   logic [15:0]          rd_active_us;
   logic                 frame_start;
   logic [NUM_CH-1:0]    pwm_out;

   modport master (
      output wr_en, wr_ch, wr_pulse_us, ch_enable, rd_ch,
      input  rd_active_us, frame_start, pwm_out
   );

   modport slave (
      input  wr_en, wr_ch, wr_pulse_us, ch_enable, rd_ch,
      output rd_active_us, frame_start, pwm_out
   );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : servo_pwm_multi                                                 |
// | Purpose  : NUM_CH hobby-servo PWM outputs sharing one frame timebase.      |
// |            Targets are clamped on write and copied (optionally slew        |
// |            limited) into the active widths only at frame boundaries, so    |
// |            pulses are never cut short or stretched.                        |
// | Ports    : clk   - system clock                                            |
// |            rst_n - asynchronous active-low reset                           |
// |            bus   - servo_pwm_multi_if.slave (write port, enables,          |
// |                    readback, frame_start, pwm_out)                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module servo_pwm_multi #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int NUM_CH     = 4,
   parameter int PERIOD_US  = 20_000,
   parameter int MIN_US     = 500,
   parameter int MAX_US     = 2_500,
   parameter int DEFAULT_US = 1_500,
   parameter int SLEW_US    = 0
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   servo_pwm_multi_if.slave bus
);

   localparam int                 C_TICKS    = CLK_FREQ / 1_000_000;
   localparam int                 C_PRE_W    = (C_TICKS > 1) ? $clog2(C_TICKS) : 1;
   localparam int                 C_US_W     = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(C_TICKS - 1);
   localparam logic [C_US_W-1:0]  C_US_LAST  = C_US_W'(PERIOD_US - 1);
   localparam logic [15:0]        C_DEF      = 16'(DEFAULT_US);
   localparam logic [15:0]        C_MIN      = 16'(MIN_US);
   localparam logic [15:0]        C_MAX      = 16'(MAX_US);

   // Timebase
   logic [C_PRE_W-1:0] pre_q, pre_d;
   logic [C_US_W-1:0]  us_q,  us_d;

   // Per-channel state
   logic [15:0]        target_q [NUM_CH];
   logic [15:0]        target_d [NUM_CH];
   logic [15:0]        active_q [NUM_CH];
   logic [15:0]        active_d [NUM_CH];
   logic [NUM_CH-1:0]  en_act_q, en_act_d;

   // Registered outputs
   logic [NUM_CH-1:0]  pwm_q, pwm_d;
   logic               frame_start_q, frame_start_d;
   logic [15:0]        rd_q, rd_d;

   logic               w_last_tick;
   logic               w_boundary;
   logic [15:0]        w_clamped;

   // One slew step from cur toward tgt. Done in 17 bits so the difference
   // and the stepped value can never wrap.
   function automatic logic [15:0] f_slew(input logic [15:0] cur, input logic [15:0] tgt);
      logic [16:0] c17;
      logic [16:0] t17;
      logic [16:0] s17;
      c17 = {1'b0, cur};
      t17 = {1'b0, tgt};
      s17 = 17'(SLEW_US);
      if (SLEW_US == 0) begin
         return tgt;
      end else if (t17 > c17) begin
         return ((t17 - c17) > s17) ? 16'(c17 + s17) : tgt;
      end else begin
         return ((c17 - t17) > s17) ? 16'(c17 - s17) : tgt;
      end
   endfunction

   always_comb begin
      w_last_tick = (pre_q == C_PRE_LAST);
      w_boundary  = w_last_tick && (us_q == C_US_LAST);

      pre_d = w_last_tick ? '0 : pre_q + C_PRE_W'(1);
      us_d  = us_q;
      if (w_boundary) begin
         us_d = '0;
      end else if (w_last_tick) begin
         us_d = us_q + C_US_W'(1);
      end

      en_act_d = w_boundary ? bus.ch_enable : en_act_q;

      if (bus.wr_pulse_us < C_MIN) begin
         w_clamped = C_MIN;
      end else if (bus.wr_pulse_us > C_MAX) begin
         w_clamped = C_MAX;
      end else begin
         w_clamped = bus.wr_pulse_us;
      end

      // Out-of-range write indices match no channel and are dropped.
      // active loads the target held before this edge, so a write landing
      // on the boundary cycle waits for the following boundary.
      // pwm is derived from next-state values so the rising edge lines up
      // with frame_start and high time is exactly active*C_TICKS cycles.
      pwm_d = '0;
      rd_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         target_d[i] = (bus.wr_en && (32'(bus.wr_ch) == i)) ? w_clamped : target_q[i];
         active_d[i] = w_boundary ? f_slew(active_q[i], target_q[i]) : active_q[i];
         pwm_d[i]    = en_act_d[i] && (32'(us_d) < 32'(active_d[i]));
         if (32'(bus.rd_ch) == i) begin
            rd_d = active_q[i];
         end
      end

      frame_start_d = w_boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q         <= '0;
         us_q          <= '0;
         en_act_q      <= '0;
         pwm_q         <= '0;
         frame_start_q <= 1'b0;
         rd_q          <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            target_q[i] <= C_DEF;
            active_q[i] <= C_DEF;
         end
      end else begin
         pre_q         <= pre_d;
         us_q          <= us_d;
         en_act_q      <= en_act_d;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
         rd_q          <= rd_d;
         for (int i = 0; i < NUM_CH; i++) begin
            target_q[i] <= target_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.rd_active_us = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_servo_pwm_multi                                              |
// | Purpose  : Scoreboard bench for servo_pwm_multi. Instance A (2 channels,   |
// |            no slew) has its per-frame high times and frame length checked |
// |            by a frame monitor; instance B (3 channels, SLEW_US=5) is       |
// |            checked through readback. Expected values are hand computed.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_servo_pwm_multi;

   localparam int CLK_FREQ   = 2_000_000;
   localparam int PERIOD_US  = 100;
   localparam int MIN_US     = 10;
   localparam int MAX_US     = 50;
   localparam int DEFAULT_US = 30;
   localparam int FRAME_CYC  = 200;

   typedef struct { int hi0; int hi1; } frame_t;
   typedef struct { int ch;  int v;   } rd_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   rq_a = 1'b0, rq_b = 1'b0;
   logic   rq_a_d = 1'b0, rq_b_d = 1'b0;
   int     fcyc = 0;
   int     checks = 0;
   int     errors = 0;

   frame_t sb_frame[$];
   rd_t    sb_rd_a[$];
   rd_t    sb_rd_b[$];

   always #5 clk = ~clk;

   servo_pwm_multi_if #(.NUM_CH(2)) bus_a ();
   servo_pwm_multi_if #(.NUM_CH(3)) bus_b ();

   servo_pwm_multi #(
      .CLK_FREQ(CLK_FREQ), .NUM_CH(2), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
      .MAX_US(MAX_US), .DEFAULT_US(DEFAULT_US), .SLEW_US(0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
   );

   servo_pwm_multi #(
      .CLK_FREQ(CLK_FREQ), .NUM_CH(3), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
      .MAX_US(MAX_US), .DEFAULT_US(DEFAULT_US), .SLEW_US(5)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Cycle position inside the current frame (1..199 are unambiguous).
   always @(posedge clk) begin
      if (!rst_n)                 fcyc <= 0;
      else if (bus_a.frame_start) fcyc <= 1;
      else                        fcyc <= fcyc + 1;
      rq_a_d <= rq_a;
      rq_b_d <= rq_b;
   end

   // Frame monitor: accumulates one frame of instance A, compares on the
   // next frame_start against the expected high times.
   initial begin : mon_frame
      int         cnt, h0, h1, late, fidx;
      logic [1:0] prev;
      frame_t     e;
      cnt = 0; h0 = 0; h1 = 0; late = 0; fidx = 0; prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cnt = 0; h0 = 0; h1 = 0; late = 0; prev = '0;
         end else begin
            if (bus_a.frame_start) begin
               if (sb_frame.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL frame%0d: frame ended with no expectation queued", fidx);
               end else begin
                  e = sb_frame.pop_front();
                  check($sformatf("frame%0d_len", fidx), cnt, FRAME_CYC);
                  check($sformatf("frame%0d_hi_ch0", fidx), h0, e.hi0);
                  check($sformatf("frame%0d_hi_ch1", fidx), h1, e.hi1);
                  check($sformatf("frame%0d_rise_off_frame_start", fidx), late, 0);
               end
               fidx++;
               cnt = 0; h0 = 0; h1 = 0; late = 0;
            end
            if (!bus_a.frame_start && ((bus_a.pwm_out & ~prev) != 2'b00)) late = 1;
            cnt++;
            h0 += int'(bus_a.pwm_out[0]);
            h1 += int'(bus_a.pwm_out[1]);
            prev = bus_a.pwm_out;
         end
      end
   end

   // Readback monitor: one cycle after a request the registered value is compared.
   initial begin : mon_rd
      rd_t e;
      forever begin
         @(negedge clk);
         if (rq_a_d) begin
            if (sb_rd_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_a: readback %0d with no expectation", bus_a.rd_active_us);
            end else begin
               e = sb_rd_a.pop_front();
               check($sformatf("rd_a_ch%0d", e.ch), int'(bus_a.rd_active_us), e.v);
            end
         end
         if (rq_b_d) begin
            if (sb_rd_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_b: readback %0d with no expectation", bus_b.rd_active_us);
            end else begin
               e = sb_rd_b.pop_front();
               check($sformatf("rd_b_ch%0d", e.ch), int'(bus_b.rd_active_us), e.v);
            end
         end
      end
   end

   task automatic push_frame(input int hi0, input int hi1);
      frame_t f;
      f.hi0 = hi0;
      f.hi1 = hi1;
      sb_frame.push_back(f);
   endtask

   task automatic wr(input bit b, input int ch, input int v);
      @(posedge clk); #1;
      if (!b) begin
         bus_a.wr_en = 1'b1; bus_a.wr_ch = 1'(ch); bus_a.wr_pulse_us = 16'(v);
      end else begin
         bus_b.wr_en = 1'b1; bus_b.wr_ch = 2'(ch); bus_b.wr_pulse_us = 16'(v);
      end
      @(posedge clk); #1;
      bus_a.wr_en = 1'b0;
      bus_b.wr_en = 1'b0;
   endtask

   task automatic rd(input bit b, input int ch, input int exp);
      rd_t r;
      r.ch = ch;
      r.v  = exp;
      @(posedge clk); #1;
      if (!b) begin
         bus_a.rd_ch = 1'(ch); sb_rd_a.push_back(r); rq_a = 1'b1;
      end else begin
         bus_b.rd_ch = 2'(ch); sb_rd_b.push_back(r); rq_b = 1'b1;
      end
      @(posedge clk); #1;
      rq_a = 1'b0;
      rq_b = 1'b0;
   endtask

   task automatic wait_fs();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_a.frame_start && n < 400);
      if (!bus_a.frame_start) begin
         checks++; errors++;
         $display("FAIL wait_frame_start: none within %0d cycles", n);
      end
   endtask

   task automatic wait_fcyc(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fcyc != target && n < 400);
      if (fcyc != target) begin
         checks++; errors++;
         $display("FAIL wait_frame_cycle: got %0d, required %0d", fcyc, target);
      end
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bus_a.wr_en = 1'b0; bus_a.wr_ch = '0; bus_a.wr_pulse_us = '0;
      bus_a.ch_enable = 2'b11; bus_a.rd_ch = '0;
      bus_b.wr_en = 1'b0; bus_b.wr_ch = '0; bus_b.wr_pulse_us = '0;
      bus_b.ch_enable = 3'b111; bus_b.rd_ch = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_pwm_a", int'(bus_a.pwm_out), 0);
      check("reset_frame_start_a", int'(bus_a.frame_start), 0);
      check("reset_rd_a", int'(bus_a.rd_active_us), 0);
      check("reset_pwm_b", int'(bus_b.pwm_out), 0);

      push_frame(0, 0);     // frame 0: enables not yet sampled
      push_frame(60, 60);   // frame 1: default 30 us on both
      rst_n = 1'b1;

      // Frame 1: new targets; B gets a slew target and an ignored index
      wait_fs();
      wr(1'b0, 0, 40);
      wr(1'b0, 1, 5);       // clamps to 10
      wr(1'b1, 0, 50);
      wr(1'b1, 3, 10);      // no such channel on B
      push_frame(80, 20);

      // Frame 2
      wait_fs();
      rd(1'b0, 0, 40);
      rd(1'b0, 1, 10);
      rd(1'b1, 0, 35);
      rd(1'b1, 3, 0);
      wr(1'b0, 1, 12);
      wr(1'b0, 1, 900);     // overwrites, clamps to 50
      push_frame(80, 100);

      // Frame 3: write exactly on the boundary cycle
      wait_fs();
      rd(1'b0, 1, 50);
      rd(1'b1, 0, 40);
      push_frame(80, 100);  // frame 4 keeps 40 us on ch0
      push_frame(40, 0);    // frame 5: 20 us on ch0, ch1 disabled
      wait_fcyc(198);
      @(posedge clk); #1;
      bus_a.wr_en = 1'b1; bus_a.wr_ch = 1'b0; bus_a.wr_pulse_us = 16'd20;
      @(posedge clk); #1;
      bus_a.wr_en = 1'b0;

      // Frame 4: drop ch1 enable at us_cnt 5
      wait_fcyc(9);
      @(posedge clk); #1;
      bus_a.ch_enable = 2'b01;
      wait_fcyc(30);
      rd(1'b1, 0, 45);

      // Frame 5: re-enable ch1
      wait_fs();
      wait_fcyc(20);
      bus_a.ch_enable = 2'b11;
      rd(1'b0, 0, 20);
      rd(1'b1, 0, 50);
      push_frame(40, 100);

      // Frame 6: B slews downward
      wait_fs();
      wait_fcyc(20);
      rd(1'b1, 0, 50);
      rd(1'b1, 1, 30);
      rd(1'b1, 2, 30);
      wr(1'b1, 0, 38);

      // Frame 7: reset asserted at us_cnt 10
      wait_fs();
      wait_fcyc(5);
      rd(1'b1, 0, 45);
      wait_fcyc(20);
      #2;
      check("pre_reset_pwm_a", int'(bus_a.pwm_out), 3);
      rst_n = 1'b0;
      #1;
      check("async_reset_pwm_a", int'(bus_a.pwm_out), 0);
      check("async_reset_frame_start_a", int'(bus_a.frame_start), 0);
      check("async_reset_pwm_b", int'(bus_b.pwm_out), 0);
      repeat (3) @(posedge clk);
      push_frame(0, 0);
      push_frame(60, 60);
      #1;
      rst_n = 1'b1;

      wait_fcyc(10);
      rd(1'b0, 0, 30);
      rd(1'b0, 1, 30);
      rd(1'b1, 0, 30);
      wait_fs();
      wait_fs();
      repeat (5) @(posedge clk);
      #1;
      check("frames_outstanding", sb_frame.size(), 0);
      check("reads_outstanding_a", sb_rd_a.size(), 0);
      check("reads_outstanding_b", sb_rd_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
